// File: rtl/clock_domain_export_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : clock_domain_export_fifo_if
//  Description : Local push port plus the req/ack/data link of the export
//                FIFO, bundled as one interface. The slave modport is the
//                export block's view; master is the view of the local
//                producer and the destination-side import block.
//  Revision    : 1.0 - initial release
// ============================================================================
interface clock_domain_export_fifo_if #(
    parameter int pBits  = 8,
    parameter int pDepth = 4
);
    localparam int c_CW = $clog2(pDepth) + 1;

    logic             stb;
    logic [pBits-1:0] data;
    logic             ready;
    logic [c_CW-1:0]  count;
    logic             idle;
    logic             overflow;
    logic             cdc_req;
    logic [pBits-1:0] cdc_data;
    logic             cdc_ack;

    modport slave (
        input  stb, data, cdc_ack,
        output ready, count, idle, overflow, cdc_req, cdc_data
    );

    modport master (
        output stb, data, cdc_ack,
        input  ready, count, idle, overflow, cdc_req, cdc_data
    );
endinterface
`default_nettype wire

// File: rtl/clock_domain_export_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : clock_domain_export_fifo
//  Description : Source half of a toggle req/ack clock-domain crossing with a
//                pDepth-entry FIFO in front of it. Words are drained one per
//                completed handshake; occupancy, idleness and a sticky
//                overflow flag are reported to the local side.
//  Revision    : 1.0 - initial release
// ============================================================================
module clock_domain_export_fifo #(
    parameter int pBits       = 8,
    parameter int pDepth      = 4,
    parameter int pSyncStages = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    clock_domain_export_fifo_if.slave   bus
);
    localparam int              c_AW    = (pDepth > 1) ? $clog2(pDepth) : 1;
    localparam int              c_CW    = $clog2(pDepth) + 1;
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(pDepth);

    logic [pBits-1:0]       mem_q [pDepth];
    logic [c_AW-1:0]        wp_q, wp_d;
    logic [c_AW-1:0]        rp_q, rp_d;
    logic [c_CW-1:0]        count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic                   req_q, req_d;
    logic [pBits-1:0]       cdc_data_q, cdc_data_d;
    logic [pSyncStages-1:0] sync_q, sync_d;

    logic ack_sync;
    logic link_free;
    logic push;
    logic launch;

    // Only the last synchroniser stage is trusted as a clean copy of cdc_ack.
    assign ack_sync  = sync_q[pSyncStages-1];
    // Link is free once the destination has echoed the last request toggle.
    assign link_free = (ack_sync == req_q);
    // Acceptance looks at the registered count only, so a full FIFO refuses
    // a push even in a cycle where it also launches a word.
    assign push      = bus.stb && (count_q != c_DEPTH);
    // Launch uses the registered count, so a freshly pushed word waits one edge.
    assign launch    = link_free && (count_q != '0);

    // Next-state computation for pointers, occupancy, flags and the link.
    always_comb begin
        wp_d       = wp_q;
        rp_d       = rp_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        req_d      = req_q;
        cdc_data_d = cdc_data_q;
        sync_d     = {sync_q[pSyncStages-2:0], bus.cdc_ack};

        if (push) begin
            wp_d = wp_q + c_AW'(1);
        end
        if (bus.stb && (count_q == c_DEPTH)) begin
            overflow_d = 1'b1;
        end
        if (launch) begin
            cdc_data_d = mem_q[rp_q];
            req_d      = ~req_q;
            rp_d       = rp_q + c_AW'(1);
        end
        if (push && !launch) begin
            count_d = count_q + c_CW'(1);
        end else if (!push && launch) begin
            count_d = count_q - c_CW'(1);
        end
    end

    // Control and link registers; reset discards queued and in-flight words.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp_q       <= '0;
            rp_q       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            req_q      <= 1'b0;
            cdc_data_q <= '0;
            sync_q     <= '0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            req_q      <= req_d;
            cdc_data_q <= cdc_data_d;
            sync_q     <= sync_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wp_q] <= bus.data;
        end
    end

    assign bus.ready    = (count_q != c_DEPTH);
    assign bus.count    = count_q;
    assign bus.idle     = (count_q == '0) && link_free;
    assign bus.overflow = overflow_q;
    assign bus.cdc_req  = req_q;
    assign bus.cdc_data = cdc_data_q;
endmodule
`default_nettype wire
